// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and defaults for the systolic array sequencer.
// Holds the controller state enum, default array width and counter width.
package systolic_pkg;

  localparam int DEF_ARRAY_WIDTH = 16;
  localparam int DEF_CNT_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD_W,
    S_SWITCH,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/systolic_skew.sv
// systolic_skew: diagonal valid delay line, o_vld[i] = i_vld delayed i cycles.
// Ports: clk, rst_n (async active-low), i_vld, o_vld[N-1:0].
module systolic_skew #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_vld,
  output logic [N-1:0] o_vld
);

  generate
    if (N > 1) begin : g_sr
      logic [N-2:0] r_sr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sr <= '0;
        end else begin
          r_sr[0] <= i_vld;
          for (int i = 1; i < N - 1; i++) begin
            r_sr[i] <= r_sr[i-1];
          end
        end
      end

      assign o_vld = {r_sr, i_vld};
    end else begin : g_wire
      assign o_vld = i_vld;
    end
  endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: one-pass sequencer for an NxN weight-stationary array.
// Ports: start/cfg/busy/done job control, w_*/a_* buffer handshakes,
// sys_* array strobes, ub_rd_col_size_* column config, res_valid_in.
// Optional SYSTOLIC_CTRL_PERF_EN adds perf_busy_cyc_out/perf_stall_cyc_out.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_WIDTH = DEF_ARRAY_WIDTH,
  parameter int CNT_W                = DEF_CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_in,
  input  logic [15:0]                     cfg_cols_in,
  input  logic [CNT_W-1:0]                cfg_rows_in,
  output logic                            busy_out,
  output logic                            done_out,
  input  logic                            w_valid_in,
  output logic                            w_ready_out,
  input  logic                            a_valid_in,
  output logic                            a_ready_out,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0] sys_accept_w_out,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0] sys_switch_out,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0] sys_valid_out,
  output logic [15:0]                     ub_rd_col_size_out,
  output logic                            ub_rd_col_size_valid_out,
`ifdef SYSTOLIC_CTRL_PERF_EN
  output logic [31:0]                     perf_busy_cyc_out,
  output logic [31:0]                     perf_stall_cyc_out,
`endif
  input  logic [SYSTOLIC_ARRAY_WIDTH-1:0] res_valid_in
);

  localparam int N = SYSTOLIC_ARRAY_WIDTH;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_k;
  logic [CNT_W-1:0] r_m;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_res;

  logic [15:0]      w_k_in;
  logic             w_start;
  logic             w_w_hs;
  logic             w_a_hs;
  logic             w_res_hit;
  logic [N-1:0]     w_col_mask;
  logic [N-1:0]     w_last_col;

  assign w_k_in  = (cfg_cols_in > 16'(N)) ? 16'(N) : cfg_cols_in;
  assign w_start = (r_state == S_IDLE) & start_in;
  assign w_w_hs  = (r_state == S_LOAD_W) & w_valid_in;
  assign w_a_hs  = (r_state == S_STREAM) & a_valid_in;

  always_comb begin
    w_col_mask = '0;
    w_last_col = '0;
    for (int j = 0; j < N; j++) begin
      w_col_mask[j] = 16'(j) < r_k;
      w_last_col[j] = 16'(j + 1) == r_k;
    end
  end

  // only the last active column marks a finished output row
  assign w_res_hit = (|(res_valid_in & w_last_col)) &
                     ((r_state == S_STREAM) | (r_state == S_DRAIN));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_in) begin
          if ((w_k_in == '0) || (cfg_rows_in == '0))
            w_next = S_DONE;
          else
            w_next = S_CFG;
        end
      end
      S_CFG:    w_next = S_LOAD_W;
      S_LOAD_W: begin
        if (w_valid_in && (r_row == CNT_W'(N - 1)))
          w_next = S_SWITCH;
      end
      S_SWITCH: w_next = S_STREAM;
      S_STREAM: begin
        if (a_valid_in && (r_row == r_m - 1'b1))
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_res == r_m)
          w_next = S_DONE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_m     <= '0;
      r_row   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_k   <= w_k_in;
        r_m   <= cfg_rows_in;
        r_row <= '0;
        r_res <= '0;
      end else begin
        // one counter serves weight rows, then input rows
        if (r_state == S_SWITCH)
          r_row <= '0;
        else if (w_w_hs | w_a_hs)
          r_row <= r_row + 1'b1;
        if (w_res_hit && (r_res != r_m))
          r_res <= r_res + 1'b1;
      end
    end
  end

  assign busy_out                 = r_state != S_IDLE;
  assign done_out                 = r_state == S_DONE;
  assign w_ready_out              = r_state == S_LOAD_W;
  assign a_ready_out              = r_state == S_STREAM;
  assign sys_accept_w_out         = w_w_hs ? w_col_mask : '0;
  assign sys_switch_out           = (r_state == S_SWITCH) ? '1 : '0;
  assign ub_rd_col_size_valid_out = r_state == S_CFG;
  assign ub_rd_col_size_out       = (r_state == S_CFG) ? r_k : '0;

  systolic_skew #(
    .N (N)
  ) u_skew (
    .clk   (clk),
    .rst_n (rst),
    .i_vld (w_a_hs),
    .o_vld (sys_valid_out)
  );

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] r_pbusy;
  logic [31:0] r_pstall;
  logic        w_stall;

  assign w_stall = ((r_state == S_LOAD_W) & ~w_valid_in) |
                   ((r_state == S_STREAM) & ~a_valid_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pbusy  <= '0;
      r_pstall <= '0;
    end else if (w_start) begin
      r_pbusy  <= '0;
      r_pstall <= '0;
    end else begin
      if (busy_out) r_pbusy  <= r_pbusy + 32'd1;
      if (w_stall)  r_pstall <= r_pstall + 32'd1;
    end
  end

  assign perf_busy_cyc_out  = r_pbusy;
  assign perf_stall_cyc_out = r_pstall;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed and randomized jobs for systolic_ctrl (N=4)
// against a handshake-counting reference model.
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_in = 1'b0;
  logic [15:0]   cfg_cols_in = '0;
  logic [CW-1:0] cfg_rows_in = '0;
  logic          busy_out, done_out;
  logic          w_valid_in = 1'b0, w_ready_out;
  logic          a_valid_in = 1'b0, a_ready_out;
  logic [N-1:0]  sys_accept_w_out, sys_switch_out, sys_valid_out;
  logic [N-1:0]  res_valid_in = '0;
  logic [15:0]   ub_rd_col_size_out;
  logic          ub_rd_col_size_valid_out;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]   perf_busy_cyc_out, perf_stall_cyc_out;
`endif

  int ntests = 0;
  int nfail  = 0;
  bit hist[$];

  always #5 clk = ~clk;

  systolic_ctrl #(
    .SYSTOLIC_ARRAY_WIDTH (N),
    .CNT_W                (CW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start_in                 (start_in),
    .cfg_cols_in              (cfg_cols_in),
    .cfg_rows_in              (cfg_rows_in),
    .busy_out                 (busy_out),
    .done_out                 (done_out),
    .w_valid_in               (w_valid_in),
    .w_ready_out              (w_ready_out),
    .a_valid_in               (a_valid_in),
    .a_ready_out              (a_ready_out),
    .sys_accept_w_out         (sys_accept_w_out),
    .sys_switch_out           (sys_switch_out),
    .sys_valid_out            (sys_valid_out),
    .ub_rd_col_size_out       (ub_rd_col_size_out),
    .ub_rd_col_size_valid_out (ub_rd_col_size_valid_out),
`ifdef SYSTOLIC_CTRL_PERF_EN
    .perf_busy_cyc_out        (perf_busy_cyc_out),
    .perf_stall_cyc_out       (perf_stall_cyc_out),
`endif
    .res_valid_in             (res_valid_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // row i valid = accepted input row seen i cycles ago
  function automatic logic [N-1:0] exp_valid(input bit cur);
    logic [N-1:0] e;
    e = '0;
    e[0] = cur;
    for (int i = 1; i < N; i++)
      if (hist.size() >= i) e[i] = hist[i-1];
    return e;
  endfunction

  task automatic cyc(input string tag, input bit v0,
                     input logic [N-1:0] acc, input logic [N-1:0] sw,
                     input bit ubv, input logic [15:0] ubs,
                     input bit wr, input bit ar, input bit bsy,
                     input bit dn, input bit pchk, input int pb,
                     input int ps);
    @(negedge clk);
    chk({tag, ".busy"}, 32'(busy_out), 32'(bsy));
    chk({tag, ".done"}, 32'(done_out), 32'(dn));
    chk({tag, ".wrdy"}, 32'(w_ready_out), 32'(wr));
    chk({tag, ".ardy"}, 32'(a_ready_out), 32'(ar));
    chk({tag, ".acc"}, 32'(sys_accept_w_out), 32'(acc));
    chk({tag, ".sw"}, 32'(sys_switch_out), 32'(sw));
    chk({tag, ".ubv"}, 32'(ub_rd_col_size_valid_out), 32'(ubv));
    chk({tag, ".ubs"}, 32'(ub_rd_col_size_out), 32'(ubs));
    chk({tag, ".valid"}, 32'(sys_valid_out), 32'(exp_valid(v0)));
`ifdef SYSTOLIC_CTRL_PERF_EN
    if (pchk) begin
      chk({tag, ".pbusy"}, perf_busy_cyc_out, pb);
      chk({tag, ".pstall"}, perf_stall_cyc_out, ps);
    end
`endif
    hist.push_front(v0);
    if (hist.size() > N) void'(hist.pop_back());
    @(posedge clk);
    #1;
  endtask

  function automatic bit pick(input int mode, input int idx);
    if (mode == 0) return 1'b1;
    if (mode == 1) return idx != 1;
    if (idx > 40) return 1'b1;
    return $urandom_range(0, 9) >= 3;
  endfunction

  task automatic mid_reset();
    a_valid_in = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rst.busy", 32'(busy_out), 0);
    chk("rst.done", 32'(done_out), 0);
    chk("rst.ardy", 32'(a_ready_out), 0);
    chk("rst.valid", 32'(sys_valid_out), 0);
    chk("rst.acc", 32'(sys_accept_w_out), 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("rst.pbusy", perf_busy_cyc_out, 0);
`endif
    hist.delete();
    @(negedge clk);
    chk("rst.done2", 32'(done_out), 0);
    chk("rst.busy2", 32'(busy_out), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_valid_in = 1'b0;
    res_valid_in = '0;
  endtask

  task automatic run_job(input int kin, input int m, input int mode,
                         input bit hold, input int rst_at);
    int keff, cnt, rows, loads, stall, bc, idx;
    bit v, p;
    logic [N-1:0] mask, r;
    keff = (kin > N) ? N : kin;
    mask = '0;
    for (int j = 0; j < keff; j++) mask[j] = 1'b1;
    cnt = 0; rows = 0; loads = 0; stall = 0; bc = 0;
    start_in = 1'b1;
    cfg_cols_in = 16'(kin);
    cfg_rows_in = CW'(m);
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (!hold) begin
      start_in = 1'b0;
      cfg_cols_in = 16'($urandom);
      cfg_rows_in = CW'($urandom);
    end
    if (keff != 0 && m != 0) begin
      cyc("cfg", 0, 0, 0, 1, 16'(keff), 0, 0, 1, 0, 0, 0, 0);
      bc++;
      idx = 0;
      while (loads < N) begin
        v = pick(mode, idx);
        w_valid_in = v;
        cyc("load", 0, v ? mask : '0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        loads += int'(v);
        stall += int'(!v);
        bc++;
        idx++;
      end
      w_valid_in = 1'b0;
      cyc("switch", 0, 0, '1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      bc++;
      idx = 0;
      while (rows < m) begin
        if (idx == rst_at) begin
          mid_reset();
          return;
        end
        v = pick(mode, idx);
        p = 1'($urandom_range(0, 1));
        r = N'($urandom);
        r[keff-1] = p;
        a_valid_in = v;
        res_valid_in = r;
        cyc("stream", v, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        rows += int'(v);
        stall += int'(!v);
        if (p && cnt < m) cnt++;
        bc++;
        idx++;
      end
      a_valid_in = 1'b0;
      idx = 0;
      forever begin
        p = (idx > 30) ? 1'b1 : 1'($urandom_range(0, 1));
        r = N'($urandom);
        r[keff-1] = p;
        res_valid_in = r;
        if (cnt == m) begin
          cyc("drain", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
          bc++;
          break;
        end
        cyc("drain", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        if (p) cnt++;
        bc++;
        idx++;
      end
      res_valid_in = '0;
    end
    cyc("done", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, bc, stall);
    if (!hold)
      cyc("after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, bc + 1, stall);
  endtask

  initial begin
    #2;
    chk("reset.busy", 32'(busy_out), 0);
    chk("reset.done", 32'(done_out), 0);
    chk("reset.wrdy", 32'(w_ready_out), 0);
    chk("reset.ardy", 32'(a_ready_out), 0);
    chk("reset.valid", 32'(sys_valid_out), 0);
    chk("reset.ubv", 32'(ub_rd_col_size_valid_out), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    run_job(4, 3, 0, 0, -1);
    run_job(2, 1, 0, 0, -1);
    run_job(4, 2, 1, 0, -1);
    run_job(4, 0, 0, 0, -1);
    run_job(0, 3, 0, 0, -1);
    run_job(9, 2, 0, 0, -1);
    run_job(4, 5, 0, 0, 2);
    run_job(3, 2, 2, 0, -1);
    run_job(4, 2, 0, 1, -1);
    run_job(4, 2, 0, 1, -1);
    run_job(3, 1, 0, 0, -1);
    for (int t = 0; t < 10; t++)
      run_job($urandom_range(0, 6), $urandom_range(0, 5), 2, 0, -1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
